// File: rtl/knockout_match_ctrl.sv
// knockout_match_ctrl: referee for a four-player bracket, scoring semi 1, semi 2 and the final in turn
module knockout_match_ctrl #(
  parameter int POINTS_TO_WIN = 3,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               point_valid,
  input  logic               point_side,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic [1:0]         match_id,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               busy,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, SEMI1, SEMI2, FINAL, DONE} state_t;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(POINTS_TO_WIN);
  state_t state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [SCORE_W-1:0] sa_q, sa_d, sb_q, sb_d, inc;
  logic in_match, win;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end
  always_comb begin
    in_match = state_q inside {SEMI1, SEMI2, FINAL};
    inc = (point_side ? sb_q : sa_q) + 1'b1;
    win = in_match && point_valid && inc == WIN;
    state_d = state_q;
    sel_d = sel_q;
    sa_d = sa_q;
    sb_d = sb_q;
    if (!in_match && start) begin
      state_d = SEMI1;
      sel_d = '0;
      sa_d = '0;
      sb_d = '0;
    end else if (win) begin
      // match_id doubles as the select index of the match being played
      sel_d[match_id] = point_side;
      sa_d = '0;
      sb_d = '0;
      state_d = state_t'(state_q + 3'd1);
    end else if (in_match && point_valid) begin
      sa_d = point_side ? sa_q : inc;
      sb_d = point_side ? inc : sb_q;
    end
  end
  assign match_id = state_q == SEMI2 ? 2'd1 : state_q == FINAL ? 2'd2 : state_q == DONE ? 2'd3 : 2'd0;
  assign {s2, s1, s0} = sel_q;
  assign score_a = sa_q;
  assign score_b = sb_q;
  assign busy = in_match;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_knockout_match_ctrl.sv
// tb_knockout_match_ctrl: random and directed bracket play on a 3-point and a 1-point referee,
// checked every cycle against a tournament-level model
module tb_knockout_match_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pv = 1'b0, ps = 1'b0;
  logic a_s0, a_s1, a_s2, a_busy, a_done, b_s0, b_s1, b_s2, b_busy, b_done;
  logic [1:0] a_mid, b_mid;
  logic [3:0] a_sa, a_sb, b_sa, b_sb;
  logic [14:0] out_v [2];
  int stg [2];
  int sc [2][2];
  bit [2:0] sel [2];
  int pw [2] = '{3, 1};
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  knockout_match_ctrl #(.POINTS_TO_WIN(3), .SCORE_W(4)) u_p3 (
    .clk(clk), .rst_n(rst_n), .start(start), .point_valid(pv), .point_side(ps),
    .s0(a_s0), .s1(a_s1), .s2(a_s2), .match_id(a_mid), .score_a(a_sa), .score_b(a_sb),
    .busy(a_busy), .done(a_done));
  knockout_match_ctrl #(.POINTS_TO_WIN(1), .SCORE_W(4)) u_p1 (
    .clk(clk), .rst_n(rst_n), .start(start), .point_valid(pv), .point_side(ps),
    .s0(b_s0), .s1(b_s1), .s2(b_s2), .match_id(b_mid), .score_a(b_sa), .score_b(b_sb),
    .busy(b_busy), .done(b_done));

  assign out_v[0] = {a_s2, a_s1, a_s0, a_mid, a_sa, a_sb, a_busy, a_done};
  assign out_v[1] = {b_s2, b_s1, b_s0, b_mid, b_sa, b_sb, b_busy, b_done};

  // stage: 0 idle, 1..3 the three matches, 4 tournament over
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      stg[k] = 0;
      sc[k][0] = 0;
      sc[k][1] = 0;
      sel[k] = 3'b000;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if ((stg[k] == 0 || stg[k] == 4) && start) begin
        stg[k] = 1;
        sc[k][0] = 0;
        sc[k][1] = 0;
        sel[k] = 3'b000;
      end else if (stg[k] >= 1 && stg[k] <= 3 && pv) begin
        sc[k][ps] = sc[k][ps] + 1;
        if (sc[k][ps] == pw[k]) begin
          sel[k][stg[k]-1] = ps;
          sc[k][0] = 0;
          sc[k][1] = 0;
          stg[k] = stg[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [14:0] exp_v(int k);
    logic [1:0] mid;
    mid = (stg[k] == 0) ? 2'd0 : 2'(stg[k] - 1);
    return {sel[k], mid, 4'(sc[k][0]), 4'(sc[k][1]), stg[k] >= 1 && stg[k] <= 3, stg[k] == 4};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    for (int k = 0; k < 2; k++) check(k == 0 ? "model_p3" : "model_p1", int'(out_v[k]), int'(exp_v(k)));
  endtask

  task automatic drive(input logic s, input logic v, input logic p);
    start = s;
    pv = v;
    ps = p;
    @(posedge clk);
    model_step();
    #1;
    start = 1'b0;
    pv = 1'b0;
    cmp_model();
  endtask

  task automatic points(input int n, input logic [15:0] sides);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, sides[n-1-i]);
  endtask

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1 cmp_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic int champ();
    return a_s2 ? (a_s1 ? 3 : 2) : (a_s0 ? 1 : 0);
  endfunction

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    check("reset_state", int'(out_v[0]), 0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b1);
    check("idle_point_ignored", int'({a_sb, a_busy}), 0);
    drive(1'b1, 1'b0, 1'b0);
    check("start_busy_mid", int'({a_busy, a_mid}), 5'b1_00 >> 0);
    points(3, 16'b000);
    check("semi1_s0_mid", int'({a_s0, a_mid}), 3'b0_01);
    points(5, 16'b10101);
    check("semi2_s1_mid", int'({a_s1, a_mid}), 3'b1_10);
    points(3, 16'b110);
    check("final_score", int'({a_sa, a_sb}), 8'h12);
    drive(1'b1, 1'b0, 1'b0);
    check("start_in_final_ignored", int'({a_sa, a_sb, a_mid}), 10'b0001_0010_10);
    drive(1'b0, 1'b1, 1'b1);
    check("bracket_selects", int'({a_s2, a_s1, a_s0}), 3'b110);
    check("bracket_done", int'({a_done, a_mid, a_busy}), 4'b1_11_0);
    check("champion", champ(), 3);
    drive(1'b0, 1'b1, 1'b0);
    check("done_point_ignored", int'(out_v[0]), 15'b110_11_0000_0000_0_1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("track1", int'({a_sa, a_sb}), 8'h01);
    drive(1'b0, 1'b1, 1'b0);
    check("track2", int'({a_sa, a_sb}), 8'h11);
    drive(1'b0, 1'b1, 1'b1);
    check("track3", int'({a_sa, a_sb}), 8'h12);
    drive(1'b0, 1'b1, 1'b1);
    check("track_win", int'({a_s0, a_sa, a_sb, a_mid}), 11'b1_0000_0000_01);
    points(6, 16'b111111);
    check("all_ones", int'({a_s2, a_s1, a_s0, a_done}), 4'b1111);
    drive(1'b1, 1'b0, 1'b0);
    check("restart", int'({a_s2, a_s1, a_s0, a_mid, a_busy, a_done}), 7'b000_00_1_0);
    points(5, 16'b00000);
    check("semi2_score_a", int'({a_mid, a_sa}), 6'b01_0010);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_p3", int'(out_v[0]), 0);
    check("async_reset_p1", int'(out_v[1]), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    points(2, 16'b01);
    check("post_reset_ignored", int'(out_v[0]), 0);
    drive(1'b1, 1'b1, 1'b1);
    check("start_with_point", int'({a_sa, a_sb, a_busy, b_sb, b_busy}), 14'b0000_0000_1_0000_1);
    pulse_reset();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("p1_semi1", int'({b_s0, b_mid}), 3'b1_01);
    drive(1'b0, 1'b1, 1'b0);
    check("p1_not_done", int'(b_done), 0);
    drive(1'b0, 1'b1, 1'b1);
    check("p1_final", int'({b_s2, b_s1, b_s0, b_done}), 4'b1011);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) pulse_reset();
      else drive($urandom_range(9) == 0, $urandom_range(3) != 0, 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/knockout_match_ctrl.md
# knockout_match_ctrl

Sequential referee for the four-player knockout bracket. It runs the three matches in order: semifinal 1 (a vs b), semifinal 2 (c vs d), then the final (winner of semi 1 vs winner of semi 2). For each match it counts point events and decides the winner. It drives the registered bracket selects s0, s1, s2 straight into the downstream winner-mux stage, which then presents the champion's 2-bit ID.

## Interface
Parameters:
- POINTS_TO_WIN, default 3: points needed to win a match; legal range 1..(2^SCORE_W − 1).
- SCORE_W, default 4: width of each score counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a tournament.
- point_valid  in  1  a point was scored this cycle.
- point_side  in  1  who scored: 0 = first competitor of the current match (a / c / semi-1 winner), 1 = second (b / d / semi-2 winner).
- s0  out  1  semifinal 1 select (0 = a, 1 = b).
- s1  out  1  semifinal 2 select (0 = c, 1 = d).
- s2  out  1  final select (0 = semi-1 winner, 1 = semi-2 winner).
- match_id  out  2  0 = IDLE/SEMI1, 1 = SEMI2, 2 = FINAL, 3 = DONE.
- score_a  out  SCORE_W  current score of the first competitor.
- score_b  out  SCORE_W  current score of the second competitor.
- busy  out  1  high in SEMI1, SEMI2 and FINAL.
- done  out  1  high in DONE; s0..s2 are then final.

## Operation
- FSM states: IDLE, SEMI1, SEMI2, FINAL, DONE. All outputs are registered or decoded directly from state.
- IDLE or DONE + start: clear s0, s1, s2, score_a and score_b to 0, then go to SEMI1.
- start in SEMI1, SEMI2 or FINAL: ignored. No restart and no state change.
- Match states + point_valid:
  - Increment score_a if point_side = 0, or score_b if point_side = 1.
  - If the incremented score equals POINTS_TO_WIN, this is the winning point. Write point_side into that match's select (SEMI1→s0, SEMI2→s1, FINAL→s2). Clear both scores. Advance SEMI1→SEMI2→FINAL→DONE.
  - Otherwise stay in the state and keep the updated score.
- point_valid in IDLE or DONE: ignored.
- start and point_valid in the same cycle in IDLE or DONE: start is taken and the point is discarded, so scores stay 0.
- Scores never exceed POINTS_TO_WIN; there are no ties and no wrap-around.
- s0 and s1 hold their values through later matches and DONE. They change only on start or reset.
- DONE persists until start or reset.

## Timing
- Reset (asynchronous assert, any state): state = IDLE; s0 = s1 = s2 = 0; scores = 0; match_id = 0; busy = 0; done = 0. Reset mid-match discards all progress.
- start sampled at edge N: busy = 1 and match_id = 0 after edge N.
- A point sampled at edge N is reflected in score_a/score_b after edge N (1-cycle latency).
- Winning point at edge N: the select bit, score clear and match_id change are all visible after edge N. The next match accepts points from edge N+1.
- Back-to-back point_valid on every cycle is supported with no bubbles.
- Fastest tournament: 3·POINTS_TO_WIN point cycles after the start cycle. done rises after the edge that samples the final's winning point.

## Test plan
- Reset check: assert rst_n low mid-SEMI2 with score_a = 2 → immediately all outputs 0 and state IDLE. After release, points are ignored until start.
- Full bracket, POINTS_TO_WIN = 3:
  - Stimulus: start; SEMI1 points 0,0,0; SEMI2 points 1,0,1,0,1; FINAL points 1,1,0,1.
  - Required: s0 = 0, s1 = 1, s2 = 1, done = 1, match_id = 3.
  - With the downstream mux (a=0,b=1,c=2,d=3), the champion reads 3.
- Score tracking: SEMI1 points 1,0,1 → score_b = 1, 1, 2 and score_a = 0, 1, 1 one cycle after each point. A further point 1 → s0 = 1, scores 0, match_id = 1.
- Ignored inputs:
  - point_valid in IDLE and in DONE → no change.
  - start during FINAL with score 2–1 → scores and state unchanged.
  - start with point_valid in IDLE → scores stay 0.
- Restart: from DONE with s0 = s1 = s2 = 1, pulse start → next cycle s0 = s1 = s2 = 0, match_id = 0, busy = 1, done = 0.
- POINTS_TO_WIN = 1 build: start plus points 1, 0, 1 on consecutive cycles → s0 = 1, s1 = 0, s2 = 1, with done high 3 cycles after start is sampled.
